// File: rtl/row_sched_if.sv
// rtl/row_sched_if.sv - beat handshake and row status bundle between datapath controller and row scheduler
interface row_sched_if;
  logic [2:0] mast_state;
  logic [2:0] slav_state;
  logic       beat_valid;
  logic       beat_ready;
  logic       sl_top_done;
  logic       sl_mid_done;
  logic       sl_bott_done;
  logic       flag_fsld_end;
  logic       flag_base_end;
  logic [8:0] now_of_row;

  modport master (
    output mast_state, slav_state, beat_valid,
    input  beat_ready, sl_top_done, sl_mid_done, sl_bott_done,
    input  flag_fsld_end, flag_base_end, now_of_row
  );

  modport slave (
    input  mast_state, slav_state, beat_valid,
    output beat_ready, sl_top_done, sl_mid_done, sl_bott_done,
    output flag_fsld_end, flag_base_end, now_of_row
  );
endinterface

// File: rtl/row_sched.sv
// rtl/row_sched.sv - counts accepted beats per phase, emits phase-end pulses and tracks the current row
module row_sched #(
  parameter int FSLD_LEN      = 16,
  parameter int TOP_LEN       = 3,
  parameter int MID_LEN       = 3,
  parameter int BOTT_LEN      = 3,
  parameter int NUM_BASE_ROWS = 4
) (
  input  logic        clk,
  input  logic        reset,
  row_sched_if.slave  bus
);
  localparam logic [2:0] M_IDLE = 3'd0;
  localparam logic [2:0] M_LEFT = 3'd1;
  localparam logic [2:0] M_BASE = 3'd2;
  localparam logic [2:0] M_RGHT = 3'd3;
  localparam logic [2:0] M_FSLD = 3'd7;
  localparam logic [2:0] S_TOP  = 3'd1;
  localparam logic [2:0] S_MID  = 3'd2;
  localparam logic [2:0] S_BOTT = 3'd3;

  localparam logic [15:0] FSLD_M1 = 16'(FSLD_LEN - 1);
  localparam logic [15:0] TOP_M1  = 16'(TOP_LEN - 1);
  localparam logic [15:0] MID_M1  = 16'(MID_LEN - 1);
  localparam logic [15:0] BOTT_M1 = 16'(BOTT_LEN - 1);
  localparam logic [8:0]  ROW_MAX = 9'd511;
  localparam logic [8:0]  BASE_LAST = 9'(NUM_BASE_ROWS);

  logic [15:0] r_beat_cnt;
  logic [8:0]  r_now_of_row;
  logic [2:0]  r_mast_q;
  logic [2:0]  r_slav_q;

  logic        w_row_mast;
  logic        w_slav_act;
  logic        w_ready;
  logic        w_acc;
  logic        w_state_chg;
  logic [15:0] w_cnt_eff;
  logic [15:0] w_len_m1;
  logic        w_last;
  logic        w_fsld;
  logic        w_bott_done;

  assign w_row_mast = (bus.mast_state == M_LEFT) || (bus.mast_state == M_BASE) ||
                      (bus.mast_state == M_RGHT);
  assign w_slav_act = (bus.slav_state == S_TOP) || (bus.slav_state == S_MID) ||
                      (bus.slav_state == S_BOTT);
  assign w_fsld     = (bus.mast_state == M_FSLD);
  assign w_ready    = w_fsld || (w_row_mast && w_slav_act);
  assign w_acc      = bus.beat_valid && w_ready;

  // A state change seen against the registered copies means the old phase is gone:
  // the count restarts from zero, and a beat accepted in that same cycle is the new phase's first.
  assign w_state_chg = (bus.mast_state != r_mast_q) || (bus.slav_state != r_slav_q);
  assign w_cnt_eff   = w_state_chg ? 16'd0 : r_beat_cnt;

  always_comb begin
    w_len_m1 = TOP_M1;
    if (w_fsld) begin
      w_len_m1 = FSLD_M1;
    end else begin
      case (bus.slav_state)
        S_MID:   w_len_m1 = MID_M1;
        S_BOTT:  w_len_m1 = BOTT_M1;
        default: w_len_m1 = TOP_M1;
      endcase
    end
  end

  assign w_last      = w_acc && (w_cnt_eff == w_len_m1);
  assign w_bott_done = w_last && !w_fsld && (bus.slav_state == S_BOTT);

  assign bus.beat_ready    = w_ready;
  assign bus.flag_fsld_end = w_last && w_fsld;
  assign bus.sl_top_done   = w_last && !w_fsld && (bus.slav_state == S_TOP);
  assign bus.sl_mid_done   = w_last && !w_fsld && (bus.slav_state == S_MID);
  assign bus.sl_bott_done  = w_bott_done;
  assign bus.flag_base_end = (bus.mast_state == M_BASE) && (r_now_of_row == BASE_LAST);
  assign bus.now_of_row    = r_now_of_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt   <= 16'd0;
      r_now_of_row <= 9'd0;
      r_mast_q     <= 3'd0;
      r_slav_q     <= 3'd0;
    end else begin
      r_mast_q <= bus.mast_state;
      r_slav_q <= bus.slav_state;

      if (bus.mast_state == M_IDLE || w_last) begin
        r_beat_cnt <= 16'd0;
      end else if (w_acc) begin
        r_beat_cnt <= w_cnt_eff + 16'd1;
      end else begin
        r_beat_cnt <= w_cnt_eff;
      end

      if (bus.mast_state == M_IDLE || w_fsld) begin
        r_now_of_row <= 9'd0;
      end else if (w_bott_done && r_now_of_row != ROW_MAX) begin
        r_now_of_row <= r_now_of_row + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_row_sched.sv
// tb/tb_row_sched.sv - directed self-checking bench for row_sched
module tb_row_sched;
  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  row_sched_if bus();

  row_sched #(
    .FSLD_LEN(4), .TOP_LEN(2), .MID_LEN(3), .BOTT_LEN(2), .NUM_BASE_ROWS(2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic [2:0] m, input logic [2:0] s, input logic v);
    bus.mast_state = m;
    bus.slav_state = s;
    bus.beat_valid = v;
  endtask

  // samples combinational outputs mid-cycle, then advances past the next rising edge
  task automatic tick(output logic rdy, output logic t, output logic m, output logic b,
                      output logic f, output logic be);
    @(negedge clk);
    rdy = bus.beat_ready;
    t   = bus.sl_top_done;
    m   = bus.sl_mid_done;
    b   = bus.sl_bott_done;
    f   = bus.flag_fsld_end;
    be  = bus.flag_base_end;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic rdy, t, m, b, f, be;
    reset = 1'b0;
    set_in(3'd7, 3'd0, 1'b1);
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (rdy !== 1'b1) $display("FAIL reset_ready_fsld got %b want 1", rdy); else n_pass++;
    n_total++;
    if ({t, m, b, f, be} !== 5'b0) $display("FAIL reset_pulses got %b want 00000", {t, m, b, f, be});
    else n_pass++;
    n_total++;
    if (bus.now_of_row !== 9'd0) $display("FAIL reset_row got %0d want 0", bus.now_of_row); else n_pass++;
    set_in(3'd1, 3'd0, 1'b1);
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (rdy !== 1'b0) $display("FAIL reset_ready_noslave got %b want 0", rdy); else n_pass++;
    set_in(3'd0, 3'd0, 1'b0);
    reset = 1'b1;
    tick(rdy, t, m, b, f, be);
  endtask

  task automatic test_fsld();
    logic rdy, t, m, b, f, be;
    logic [3:0] pat;
    set_in(3'd7, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(rdy, t, m, b, f, be);
      pat[i] = f;
    end
    set_in(3'd7, 3'd0, 1'b0);
    n_total++;
    if (pat !== 4'b1000) $display("FAIL fsld_end_pattern got %b want 1000", pat); else n_pass++;
    n_total++;
    if (dut.r_beat_cnt !== 16'd0) $display("FAIL fsld_cnt_after got %0d want 0", dut.r_beat_cnt);
    else n_pass++;
  endtask

  task automatic test_toggle();
    logic rdy, t, m, b, f, be;
    logic [2:0] pat;
    logic [2:0] vseq;
    vseq = 3'b101;
    for (int i = 0; i < 3; i++) begin
      set_in(3'd1, 3'd1, vseq[i]);
      tick(rdy, t, m, b, f, be);
      pat[i] = t;
    end
    set_in(3'd1, 3'd1, 1'b0);
    n_total++;
    if (pat !== 3'b100) $display("FAIL toggle_top_done got %b want 100", pat); else n_pass++;
  endtask

  task automatic test_no_slave();
    logic rdy, t, m, b, f, be;
    int n_rdy, n_pulse;
    n_rdy = 0;
    n_pulse = 0;
    set_in(3'd1, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(rdy, t, m, b, f, be);
      n_rdy += int'(rdy);
      n_pulse += int'(t) + int'(m) + int'(b) + int'(f);
    end
    n_total++;
    if (n_rdy !== 0) $display("FAIL noslave_ready got %0d want 0", n_rdy); else n_pass++;
    n_total++;
    if (n_pulse !== 0) $display("FAIL noslave_pulses got %0d want 0", n_pulse); else n_pass++;
    n_total++;
    if (dut.r_beat_cnt !== 16'd0) $display("FAIL noslave_cnt got %0d want 0", dut.r_beat_cnt);
    else n_pass++;
    set_in(3'd4, 3'd1, 1'b1);
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (rdy !== 1'b0) $display("FAIL unused_mast_ready got %b want 0", rdy); else n_pass++;
  endtask

  task automatic test_frame();
    logic rdy, t, m, b, f, be;
    int lens[3];
    int n_t, n_m, n_b, n_be, n_base2;
    logic [2:0] mst;
    lens = '{2, 3, 2};
    n_t = 0; n_m = 0; n_b = 0; n_be = 0; n_base2 = 0;
    set_in(3'd0, 3'd0, 1'b0);
    tick(rdy, t, m, b, f, be);
    for (int r = 0; r < 4; r++) begin
      mst = (r == 0) ? 3'd1 : ((r == 3) ? 3'd3 : 3'd2);
      for (int ph = 0; ph < 3; ph++) begin
        set_in(mst, 3'(ph + 1), 1'b1);
        n_total++;
        if (bus.now_of_row !== 9'(r))
          $display("FAIL frame_row_r%0d_p%0d got %0d want %0d", r, ph, bus.now_of_row, r);
        else n_pass++;
        for (int k = 0; k < lens[ph]; k++) begin
          tick(rdy, t, m, b, f, be);
          n_t += int'(t); n_m += int'(m); n_b += int'(b); n_be += int'(be);
          if (r == 2) n_base2 += int'(be);
        end
      end
    end
    set_in(3'd3, 3'd0, 1'b0);
    n_total++;
    if (n_b !== 4) $display("FAIL frame_bott_done got %0d want 4", n_b); else n_pass++;
    n_total++;
    if (n_t !== 4 || n_m !== 4) $display("FAIL frame_top_mid got %0d/%0d want 4/4", n_t, n_m);
    else n_pass++;
    n_total++;
    if (n_be !== 7 || n_base2 !== 7)
      $display("FAIL frame_base_end got %0d (row2 %0d) want 7 (row2 7)", n_be, n_base2);
    else n_pass++;
    n_total++;
    if (bus.now_of_row !== 9'd4) $display("FAIL frame_row_end got %0d want 4", bus.now_of_row);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic rdy, t, m, b, f, be;
    logic [2:0] pat;
    set_in(3'd0, 3'd0, 1'b0);
    tick(rdy, t, m, b, f, be);
    set_in(3'd2, 3'd2, 1'b1);
    tick(rdy, t, m, b, f, be);
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (dut.r_beat_cnt !== 16'd2) $display("FAIL rstmid_cnt_before got %0d want 2", dut.r_beat_cnt);
    else n_pass++;
    bus.beat_valid = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    n_total++;
    if (dut.r_beat_cnt !== 16'd0 || bus.now_of_row !== 9'd0)
      $display("FAIL rstmid_async_clear got cnt %0d row %0d want 0 0", dut.r_beat_cnt, bus.now_of_row);
    else n_pass++;
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (m !== 1'b0) $display("FAIL rstmid_no_done got %b want 0", m); else n_pass++;
    reset = 1'b1;
    tick(rdy, t, m, b, f, be);
    bus.beat_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(rdy, t, m, b, f, be);
      pat[i] = m;
    end
    bus.beat_valid = 1'b0;
    n_total++;
    if (pat !== 3'b100) $display("FAIL rstmid_resume_done got %b want 100", pat); else n_pass++;
  endtask

  task automatic test_idle_abort();
    logic rdy, t, m, b, f, be;
    set_in(3'd1, 3'd3, 1'b1);
    tick(rdy, t, m, b, f, be);
    tick(rdy, t, m, b, f, be);
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (bus.now_of_row !== 9'd1 || dut.r_beat_cnt !== 16'd1)
      $display("FAIL abort_setup got row %0d cnt %0d want 1 1", bus.now_of_row, dut.r_beat_cnt);
    else n_pass++;
    set_in(3'd0, 3'd3, 1'b1);
    tick(rdy, t, m, b, f, be);
    n_total++;
    if (b !== 1'b0 || rdy !== 1'b0) $display("FAIL abort_no_done got done %b rdy %b want 0 0", b, rdy);
    else n_pass++;
    n_total++;
    if (dut.r_beat_cnt !== 16'd0 || bus.now_of_row !== 9'd0)
      $display("FAIL abort_clear got cnt %0d row %0d want 0 0", dut.r_beat_cnt, bus.now_of_row);
    else n_pass++;
  endtask

  task automatic test_slave_switch();
    logic rdy, t, m, b, f, be;
    logic [2:0] pat;
    set_in(3'd1, 3'd1, 1'b1);
    tick(rdy, t, m, b, f, be);
    set_in(3'd1, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(rdy, t, m, b, f, be);
      pat[i] = m | t;
    end
    n_total++;
    if (pat !== 3'b100) $display("FAIL switch_mid_done got %b want 100", pat); else n_pass++;
  endtask

  task automatic test_saturate();
    logic rdy, t, m, b, f, be;
    set_in(3'd0, 3'd0, 1'b0);
    tick(rdy, t, m, b, f, be);
    set_in(3'd1, 3'd3, 1'b1);
    for (int i = 0; i < 1030; i++) tick(rdy, t, m, b, f, be);
    n_total++;
    if (bus.now_of_row !== 9'd511) $display("FAIL row_saturate got %0d want 511", bus.now_of_row);
    else n_pass++;
    set_in(3'd0, 3'd0, 1'b0);
    tick(rdy, t, m, b, f, be);
  endtask

  initial begin
    set_in(3'd0, 3'd0, 1'b0);
    test_reset();
    test_fsld();
    test_toggle();
    test_no_slave();
    test_frame();
    test_reset_mid();
    test_idle_abort();
    test_slave_switch();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
